// File: rtl/des_seq_pkg.sv
// Shared types and helpers for the block-cipher sequencer: FSM states,
// a ceil-log2 helper and the per-block cycle-count formula.
package des_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_STORE,
    S_NEXT,
    S_DONE
  } state_e;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Cycles spent per block: LOAD (wpb+1), ROUND, STORE (wpb), NEXT (1).
  function automatic int block_period(input int words_per_block, input int num_rounds);
    return 2 * words_per_block + num_rounds + 2;
  endfunction

endpackage

// File: rtl/des_block_seq_if.sv
// Control, RAM and cipher-core signals of the sequencer; master is the
// sequencer side, slave is the surrounding system (RAMs, core, controller).
interface des_block_seq_if
  import des_seq_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int WORDS_PER_BLOCK = 2,
  parameter int ADDR_W          = 9,
  parameter int NUM_ROUNDS      = 16
) ();
  localparam int BLOCK_W = DATA_W * WORDS_PER_BLOCK;
  localparam int BLK_W   = ADDR_W - clog2_f(WORDS_PER_BLOCK);
  localparam int RND_W   = (NUM_ROUNDS > 1) ? clog2_f(NUM_ROUNDS) : 1;

  logic               start;
  logic               cbc;
  logic               decrypt;
  logic [BLK_W-1:0]   num_blocks;
  logic [BLOCK_W-1:0] iv;
  logic [ADDR_W-1:0]  ram_i_addr;
  logic [DATA_W-1:0]  ram_i_dout;
  logic [ADDR_W-1:0]  ram_o_addr;
  logic [DATA_W-1:0]  ram_o_din;
  logic               ram_o_we;
  logic [BLOCK_W-1:0] core_in;
  logic [RND_W-1:0]   core_round;
  logic               core_decrypt;
  logic [BLOCK_W-1:0] core_out;
  logic               busy;
  logic               done;
  logic [BLK_W:0]     blocks_done;

  modport master (
    input  start, cbc, decrypt, num_blocks, iv, ram_i_dout, core_out,
    output ram_i_addr, ram_o_addr, ram_o_din, ram_o_we,
           core_in, core_round, core_decrypt, busy, done, blocks_done
  );

  modport slave (
    output start, cbc, decrypt, num_blocks, iv, ram_i_dout, core_out,
    input  ram_i_addr, ram_o_addr, ram_o_din, ram_o_we,
           core_in, core_round, core_decrypt, busy, done, blocks_done
  );

endinterface

// File: rtl/des_chain_unit.sv
// CBC chaining: pre-whitening of the core input, post-whitening of the
// core output and the chain register that carries state between blocks.
module des_chain_unit #(
  parameter int BLOCK_W = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cbc,
  input  logic               decrypt,
  input  logic               load_iv,
  input  logic               update,
  input  logic [BLOCK_W-1:0] iv,
  input  logic [BLOCK_W-1:0] block,
  input  logic [BLOCK_W-1:0] core_out,
  output logic [BLOCK_W-1:0] core_in,
  output logic [BLOCK_W-1:0] result
);

  logic [BLOCK_W-1:0] chain_q, chain_d;

  always_comb begin
    core_in = (cbc && !decrypt) ? (block ^ chain_q) : block;
    result  = (cbc && decrypt) ? (core_out ^ chain_q) : core_out;
    chain_d = chain_q;
    if (load_iv) begin
      chain_d = iv;
    end else if (update && cbc) begin
      // Decrypt chains on the ciphertext that came in, encrypt on the one going out.
      chain_d = decrypt ? block : core_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) chain_q <= '0;
    else       chain_q <= chain_d;
  end

endmodule

// File: rtl/des_block_seq.sv
// Streams N cipher blocks from the input RAM through an iterative round core
// into the output RAM, with ECB or CBC chaining in either direction.
module des_block_seq
  import des_seq_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int WORDS_PER_BLOCK = 2,
  parameter int ADDR_W          = 9,
  parameter int NUM_ROUNDS      = 16
) (
  input  logic            sys_clk,
  input  logic            reset,
  des_block_seq_if.master bus
);

  localparam int WPB_LOG = clog2_f(WORDS_PER_BLOCK);
  localparam int BLOCK_W = DATA_W * WORDS_PER_BLOCK;
  localparam int BLK_W   = ADDR_W - WPB_LOG;
  localparam int RND_W   = (NUM_ROUNDS > 1) ? clog2_f(NUM_ROUNDS) : 1;
  localparam int CNT_MAX = (WORDS_PER_BLOCK + 1 > NUM_ROUNDS) ? WORDS_PER_BLOCK + 1 : NUM_ROUNDS;
  localparam int CNT_W   = clog2_f(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] STORE_LAST = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0] ROUND_LAST = CNT_W'(NUM_ROUNDS - 1);
  localparam logic [BLK_W:0]   FULL_RUN   = {1'b1, {BLK_W{1'b0}}};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLK_W-1:0]   blk_idx_q, blk_idx_d;
  logic [BLK_W:0]     blocks_done_q, blocks_done_d;
  logic [BLK_W:0]     target_q, target_d;
  logic [BLK_W:0]     blocks_inc;
  logic               cbc_q, cbc_d;
  logic               decrypt_q, decrypt_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic [BLOCK_W-1:0] result_q, result_d;
  logic [ADDR_W-1:0]  base_addr, cur_addr;
  logic               chain_load, chain_update;
  logic [BLOCK_W-1:0] chain_core_in, chain_result;

  assign base_addr  = ADDR_W'(blk_idx_q) << WPB_LOG;
  assign cur_addr   = base_addr + ADDR_W'(cnt_q);
  assign blocks_inc = blocks_done_q + 1'b1;

  des_chain_unit #(.BLOCK_W(BLOCK_W)) u_chain (
    .clk      (sys_clk),
    .reset    (reset),
    .cbc      (cbc_q),
    .decrypt  (decrypt_q),
    .load_iv  (chain_load),
    .update   (chain_update),
    .iv       (bus.iv),
    .block    (block_q),
    .core_out (bus.core_out),
    .core_in  (chain_core_in),
    .result   (chain_result)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    state_d          = state_q;
    cnt_d            = cnt_q;
    blk_idx_d        = blk_idx_q;
    blocks_done_d    = blocks_done_q;
    target_d         = target_q;
    cbc_d            = cbc_q;
    decrypt_d        = decrypt_q;
    block_d          = block_q;
    result_d         = result_q;
    chain_load       = 1'b0;
    chain_update     = 1'b0;
    bus.ram_i_addr   = '0;
    bus.ram_o_addr   = '0;
    bus.ram_o_din    = '0;
    bus.ram_o_we     = 1'b0;
    bus.core_in      = '0;
    bus.core_round   = '0;
    bus.done         = 1'b0;
    bus.busy         = (state_q != S_IDLE);
    bus.core_decrypt = decrypt_q;
    bus.blocks_done  = blocks_done_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d       = S_LOAD;
          cnt_d         = '0;
          blk_idx_d     = '0;
          blocks_done_d = '0;
          target_d      = (bus.num_blocks == '0) ? FULL_RUN : {1'b0, bus.num_blocks};
          cbc_d         = bus.cbc;
          decrypt_d     = bus.decrypt;
          chain_load    = 1'b1;
        end
      end

      S_LOAD: begin
        // Address goes out in cycle k, its data is captured one cycle later.
        if (cnt_q < LOAD_LAST) bus.ram_i_addr = cur_addr;
        for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
          if (cnt_q == CNT_W'(k + 1)) block_d[k*DATA_W +: DATA_W] = bus.ram_i_dout;
        end
        if (cnt_q == LOAD_LAST) begin
          state_d = S_ROUND;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_ROUND: begin
        bus.core_in    = chain_core_in;
        bus.core_round = cnt_q[RND_W-1:0];
        if (cnt_q == ROUND_LAST) begin
          result_d     = chain_result;
          chain_update = 1'b1;
          state_d      = S_STORE;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STORE: begin
        bus.ram_o_we   = 1'b1;
        bus.ram_o_addr = cur_addr;
        for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
          if (cnt_q == CNT_W'(k)) bus.ram_o_din = result_q[k*DATA_W +: DATA_W];
        end
        if (cnt_q == STORE_LAST) begin
          state_d = S_NEXT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_NEXT: begin
        blocks_done_d = blocks_inc;
        if (blocks_inc == target_q) begin
          state_d = S_DONE;
        end else begin
          state_d   = S_LOAD;
          blk_idx_d = blk_idx_q + 1'b1;
          cnt_d     = '0;
        end
      end

      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      blk_idx_q     <= '0;
      blocks_done_q <= '0;
      target_q      <= '0;
      cbc_q         <= 1'b0;
      decrypt_q     <= 1'b0;
      block_q       <= '0;
      result_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      blk_idx_q     <= blk_idx_d;
      blocks_done_q <= blocks_done_d;
      target_q      <= target_d;
      cbc_q         <= cbc_d;
      decrypt_q     <= decrypt_d;
      block_q       <= block_d;
      result_q      <= result_d;
    end
  end

endmodule

// File: tb/tb_des_block_seq.sv
// Bench for des_block_seq: inverting core stub, 1-cycle input RAM, write
// scoreboard, table of short runs plus full-RAM, restart and reset sequences.
`timescale 1ns/1ps
module tb_des_block_seq;
  import des_seq_pkg::*;

  localparam int DATA_W     = 32;
  localparam int WPB        = 2;
  localparam int ADDR_W     = 9;
  localparam int NUM_ROUNDS = 16;
  localparam int P          = block_period(WPB, NUM_ROUNDS);

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 sys_clk = ~sys_clk;

  des_block_seq_if #(.DATA_W(DATA_W), .WORDS_PER_BLOCK(WPB), .ADDR_W(ADDR_W),
                     .NUM_ROUNDS(NUM_ROUNDS)) bus ();

  des_block_seq #(.DATA_W(DATA_W), .WORDS_PER_BLOCK(WPB), .ADDR_W(ADDR_W),
                  .NUM_ROUNDS(NUM_ROUNDS)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  logic [31:0] ram_in [512];
  always @(posedge sys_clk) bus.ram_i_dout <= ram_in[bus.ram_i_addr];
  assign bus.core_out = ~bus.core_in;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  always @(negedge sys_clk) begin
    if (bus.ram_o_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {55'd0, bus.ram_o_addr}, 64'h1ff);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", {55'd0, bus.ram_o_addr}, {55'd0, mon_e.addr});
        check("wr_data", {32'd0, bus.ram_o_din}, {32'd0, mon_e.data});
      end
    end
  end

  task automatic push_block(input int b, input logic [63:0] v);
    wr_t w;
    w.addr = 9'((2 * b) % 512);
    w.data = v[31:0];
    exp_q.push_back(w);
    w.addr = 9'((2 * b + 1) % 512);
    w.data = v[63:32];
    exp_q.push_back(w);
  endtask

  // Reference chaining with core = bitwise NOT.
  task automatic push_model(input logic cbc, input logic dec, input logic [7:0] nb,
                            input logic [63:0] iv);
    logic [63:0] chain, blk, o;
    int cnt;
    cnt   = (nb == 8'd0) ? 256 : int'(nb);
    chain = iv;
    for (int b = 0; b < cnt; b++) begin
      blk = {ram_in[(2 * b + 1) % 512], ram_in[(2 * b) % 512]};
      if (!cbc) begin
        o = ~blk;
      end else if (!dec) begin
        o = ~(blk ^ chain);
        chain = o;
      end else begin
        o = ~blk ^ chain;
        chain = blk;
      end
      push_block(b, o);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctrl"}, {29'd0, bus.ram_i_addr, bus.ram_o_addr, bus.ram_o_we, bus.core_round,
                           bus.core_decrypt, bus.busy, bus.done, bus.blocks_done}, 64'd0);
    check({tag, "_din"}, {32'd0, bus.ram_o_din}, 64'd0);
    check({tag, "_core_in"}, bus.core_in, 64'd0);
  endtask

  task automatic start_run(input logic cbc, input logic dec, input logic [7:0] nb,
                           input logic [63:0] iv);
    @(negedge sys_clk);
    bus.cbc        = cbc;
    bus.decrypt    = dec;
    bus.num_blocks = nb;
    bus.iv         = iv;
    bus.start      = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
  endtask

  task automatic run_dut(input logic cbc, input logic dec, input logic [7:0] nb,
                         input logic [63:0] iv, input logic disturb,
                         input int exp_done, input int exp_bd);
    int n, budget;
    bit seen;
    budget = ((nb == 8'd0) ? 256 : int'(nb)) * P + 50;
    start_run(cbc, dec, nb, iv);
    n    = 1;
    seen = 1'b0;
    while (n <= budget && !seen) begin
      if (n == 5)  check("core_decrypt", {63'd0, bus.core_decrypt}, {63'd0, dec});
      if (n == 19) check("core_round_last", {60'd0, bus.core_round}, 64'(NUM_ROUNDS - 1));
      if (disturb && n == 10) begin
        bus.start      = 1'b1;
        bus.cbc        = ~cbc;
        bus.decrypt    = ~dec;
        bus.iv         = ~iv;
        bus.num_blocks = nb + 8'd3;
      end
      if (disturb && n == 11) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
      end else begin
        @(negedge sys_clk);
        n++;
      end
    end
    check("done_cycle", seen ? 64'(n) : 64'hdead, 64'(exp_done));
    if (seen) begin
      check("busy_at_done", {63'd0, bus.busy}, 64'd1);
      check("blocks_done", {55'd0, bus.blocks_done}, 64'(exp_bd));
      @(negedge sys_clk);
      check("idle_after_done", {62'd0, bus.busy, bus.done}, 64'd0);
      check("blocks_done_hold", {55'd0, bus.blocks_done}, 64'(exp_bd));
    end
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  typedef struct {
    logic        cbc;
    logic        dec;
    logic [7:0]  nblk;
    logic [63:0] iv;
    logic [63:0] in0, in1;
    logic [63:0] exp0, exp1;
    logic        disturb;
    int          exp_done;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad;

    vecs[0] = '{1'b0, 1'b0, 8'd1, 64'h0, 64'h89AB_CDEF_0123_4567, 64'h0,
                64'h7654_3210_FEDC_BA98, 64'h0, 1'b0, 23};
    vecs[1] = '{1'b1, 1'b0, 8'd2, 64'hFFFF_FFFF_0000_0000, 64'h0, 64'h0,
                64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 1'b0, 45};
    vecs[2] = '{1'b1, 1'b1, 8'd2, 64'hFFFF_FFFF_0000_0000,
                64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 64'h0, 64'h0, 1'b0, 45};
    vecs[3] = '{1'b1, 1'b0, 8'd1, 64'h0F0F_0F0F_F0F0_F0F0, 64'h0123_4567_89AB_CDEF, 64'h0,
                64'hF1D3_B597_86A4_C2E0, 64'h0, 1'b0, 23};
    vecs[4] = '{1'b0, 1'b1, 8'd2, 64'h1234_5678_9ABC_DEF0,
                64'hDEAD_BEEF_CAFE_F00D, 64'h0000_FFFF_1234_5678,
                64'h2152_4110_3501_0FF2, 64'hFFFF_0000_EDCB_A987, 1'b1, 45};
    vecs[5] = '{1'b1, 1'b1, 8'd2, 64'h0,
                64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                64'hEEEE_DDDD_CCCC_BBBB, 64'hBBBB_BBBB_BBBB_3333, 1'b1, 45};

    bus.start      = 1'b0;
    bus.cbc        = 1'b0;
    bus.decrypt    = 1'b1;
    bus.num_blocks = '0;
    bus.iv         = '1;
    for (int a = 0; a < 512; a++) ram_in[a] = 32'h0;

    repeat (3) @(negedge sys_clk);
    check_idle_outputs("reset_state");

    // Reset wins over a simultaneous start.
    bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    reset     = 1'b0;
    check("reset_beats_start", {63'd0, bus.busy}, 64'd0);
    @(negedge sys_clk);
    check("still_idle", {63'd0, bus.busy}, 64'd0);

    for (int i = 0; i < 6; i++) begin
      {ram_in[1], ram_in[0]} = vecs[i].in0;
      {ram_in[3], ram_in[2]} = vecs[i].in1;
      push_block(0, vecs[i].exp0);
      if (vecs[i].nblk == 8'd2) push_block(1, vecs[i].exp1);
      run_dut(vecs[i].cbc, vecs[i].dec, vecs[i].nblk, vecs[i].iv, vecs[i].disturb,
              vecs[i].exp_done, int'(vecs[i].nblk));
    end

    // Full-RAM run, then a short run that must start back at address 0.
    for (int a = 0; a < 512; a++) ram_in[a] = (a * 32'h9E37_79B9) ^ 32'h0000_5555;
    push_model(1'b0, 1'b0, 8'd0, 64'h0);
    run_dut(1'b0, 1'b0, 8'd0, 64'h0, 1'b0, 256 * P + 1, 256);
    push_model(1'b0, 1'b0, 8'd1, 64'h0);
    run_dut(1'b0, 1'b0, 8'd1, 64'h0, 1'b0, P + 1, 1);

    // Reset during the first STORE cycle of block 3.
    push_model(1'b1, 1'b1, 8'd5, 64'hA5A5_5A5A_0F0F_F0F0);
    start_run(1'b1, 1'b1, 8'd5, 64'hA5A5_5A5A_0F0F_F0F0);
    n = 1;
    while (n < 3 * P + 20) begin
      @(negedge sys_clk);
      n++;
    end
    check("store_before_reset", {63'd0, bus.ram_o_we}, 64'd1);
    reset = 1'b1;
    @(negedge sys_clk);
    check_idle_outputs("after_abort");
    check("writes_left_after_abort", 64'(exp_q.size()), 64'd3);
    exp_q.delete();
    @(negedge sys_clk);
    reset = 1'b0;
    bad   = 0;
    repeat (30) begin
      @(negedge sys_clk);
      if (bus.done !== 1'b0 || bus.ram_o_we !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    check("quiet_after_abort", 64'(bad), 64'd0);

    push_model(1'b1, 1'b0, 8'd2, 64'h0123_4567_89AB_CDEF);
    run_dut(1'b1, 1'b0, 8'd2, 64'h0123_4567_89AB_CDEF, 1'b0, 2 * P + 1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/des_block_seq.md
Name: des_block_seq

Overview:
Parametrised block-cipher sequencer that succeeds the fixed DES block loop. It streams N blocks from an input block-RAM port through an external iterative round core (such as the DES core) into an output block-RAM port. It supports ECB and CBC chaining, a programmable block count, and configurable word/round geometry. It sits between the pipe-fed input/output RAMs and the cipher core, all in the sys_clk domain.

Parameters:
DATA_W, 32, RAM word width
WORDS_PER_BLOCK, 2, RAM words per cipher block (power of 2, >=1)
ADDR_W, 9, RAM address width
NUM_ROUNDS, 16, core rounds per block (>=1)
Derived: BLOCK_W = DATA_W*WORDS_PER_BLOCK; BLK_W = ADDR_W - clog2(WORDS_PER_BLOCK)

Ports:
sys_clk  in  1  sole clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle request; honoured only when idle
cbc  in  1  1=CBC, 0=ECB; latched at start
decrypt  in  1  direction; latched at start, drives core_decrypt
num_blocks  in  BLK_W  blocks to process; 0 means 2^BLK_W (full RAM)
iv  in  BLOCK_W  CBC initial vector; latched at start
ram_i_addr  out  ADDR_W  input RAM read address (1-cycle read latency)
ram_i_dout  in  DATA_W  input RAM read data
ram_o_addr  out  ADDR_W  output RAM write address
ram_o_din  out  DATA_W  output RAM write data
ram_o_we  out  1  output RAM write enable
core_in  out  BLOCK_W  block presented to the core, held through ROUND
core_round  out  4+  round select (width clog2(NUM_ROUNDS)); 0 outside ROUND
core_decrypt  out  1  latched decrypt
core_out  in  BLOCK_W  core result; valid in the cycle core_round==NUM_ROUNDS-1
busy  out  1  high from the cycle after start is accepted until DONE completes
done  out  1  one-cycle pulse on completion
blocks_done  out  BLK_W+1  blocks written in the current/last run

Behaviour:
- Reset: every output is 0; state IDLE; chain register and counters are 0. Reset mid-run aborts immediately: no further writes, no done pulse.
- Reset has priority over start in the same cycle. start while busy is ignored (no restart, no queueing).
- Word order: word k of a block sits at address base+k and occupies bits [DATA_W*(k+1)-1 : DATA_W*k]. base = block_index*WORDS_PER_BLOCK. Addresses wrap modulo 2^ADDR_W.
- FSM: IDLE -> LOAD -> ROUND -> STORE -> NEXT -> (LOAD | DONE) -> IDLE.
- LOAD, WORDS_PER_BLOCK+1 cycles: cycle k issues address base+k (k<WPB) and captures ram_i_dout into word k-1 (k>=1).
- ROUND, NUM_ROUNDS cycles: core_round counts 0..NUM_ROUNDS-1. In the final cycle, core_out is sampled into the result register.
- STORE, WPB cycles: ram_o_we=1, ram_o_addr=base+k, ram_o_din=result word k.
- NEXT, 1 cycle: increments blocks_done. Goes to DONE if blocks_done reaches the target (0 -> 2^BLK_W), otherwise to LOAD with the next base.
- DONE, 1 cycle: done=1, busy drops at the following edge.
- Per-block period P = 2*WPB + NUM_ROUNDS + 2 (22 cycles with defaults). With start sampled in cycle 0, done is high in cycle N*P+1.
- ECB: core_in = block; output = core_out.
- CBC encrypt: core_in = block XOR chain; output = core_out; chain <= core_out.
- CBC decrypt: core_in = block; output = core_out XOR chain; chain <= block (ciphertext).
- chain <= latched iv at start in both CBC directions.
- blocks_done is cleared at start and holds its final value after DONE until the next start.
- Inputs cbc, decrypt, iv and num_blocks may change during busy without effect.

Decomposition:
- Package des_seq_pkg: FSM state enumeration; the P-formula as a function; clog2 helper.
- Optional sub-module des_chain_unit: the combinational CBC XOR/select logic plus the chain register with load/update enables.
- Everything else lives in des_block_seq.

Test Plan:
- Bench core stub: core_out = ~core_in, with defaults throughout.
- ECB, num_blocks=1, RAM[0]=32'h0123_4567, RAM[1]=32'h89AB_CDEF -> out RAM[0]=32'hFEDC_BA98, RAM[1]=32'h7654_3210; done high exactly in cycle 23; blocks_done=1.
- CBC encrypt, iv=64'hFFFF_FFFF_0000_0000, 2 blocks of all-zero -> C0=64'h0000_0000_FFFF_FFFF, C1=~(0 XOR C0)=64'hFFFF_FFFF_0000_0000; done in cycle 45.
- CBC decrypt of the previous output with the same iv -> plaintext recovered, with the model core's inverse applied (bench computes ~C XOR chain). Check chain updates from ciphertext, not from core_out.
- num_blocks=0 -> 256 blocks processed; final write to address 511; addresses wrap to 0 on the next run; done in cycle 256*22+1.
- start pulsed again mid-run, plus iv/cbc toggled while busy -> no effect on output or timing.
- reset asserted during STORE of block 3 -> ram_o_we low from the next cycle, no done pulse, all outputs 0. A subsequent start then runs normally.
